// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with EX-side RAW operand forwarding from MEM and WB.
// Build option: define EX_FWD_EN to enable forwarding, stall-time WB refresh and same-edge WB bypass.
module id_ex_operand_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_alu_op,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic              id_alusrc,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              id_regwrite,
  input  logic              mem_regwrite,
  input  logic [REG_AW-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_alu_op,
  output logic [DATA_W-1:0] ex_A,
  output logic [DATA_W-1:0] ex_B,
  output logic [DATA_W-1:0] ex_rt_fwd,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic              ex_regwrite
);

  localparam logic [REG_AW-1:0] R0 = '0;

  // Held ID/EX fields
  logic              valid_q,    valid_d;
  logic [OP_W-1:0]   alu_op_q,   alu_op_d;
  logic [REG_AW-1:0] rs_addr_q,  rs_addr_d;
  logic [REG_AW-1:0] rt_addr_q,  rt_addr_d;
  logic [DATA_W-1:0] rs_data_q,  rs_data_d;
  logic [DATA_W-1:0] rt_data_q,  rt_data_d;
  logic [DATA_W-1:0] imm_q,      imm_d;
  logic              alusrc_q,   alusrc_d;
  logic [REG_AW-1:0] rd_addr_q,  rd_addr_d;
  logic              regwrite_q, regwrite_d;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

`ifdef EX_FWD_EN
  logic wb_live;
  logic mem_live;
  logic wb_hit_id_rs;
  logic wb_hit_id_rt;
  logic wb_hit_rs;
  logic wb_hit_rt;
  logic mem_hit_rs;
  logic mem_hit_rt;

  // r0 is never a forwarding source or target
  assign wb_live      = wb_regwrite  && (wb_rd_addr  != R0);
  assign mem_live     = mem_regwrite && (mem_rd_addr != R0);
  assign wb_hit_id_rs = wb_live  && (wb_rd_addr  == id_rs_addr);
  assign wb_hit_id_rt = wb_live  && (wb_rd_addr  == id_rt_addr);
  assign wb_hit_rs    = wb_live  && (wb_rd_addr  == rs_addr_q);
  assign wb_hit_rt    = wb_live  && (wb_rd_addr  == rt_addr_q);
  assign mem_hit_rs   = mem_live && (mem_rd_addr == rs_addr_q);
  assign mem_hit_rt   = mem_live && (mem_rd_addr == rt_addr_q);
`endif

  // Next-state selection: flush > stall > load (reset handled in the register)
  always_comb begin
    valid_d    = valid_q;
    alu_op_d   = alu_op_q;
    rs_addr_d  = rs_addr_q;
    rt_addr_d  = rt_addr_q;
    rs_data_d  = rs_data_q;
    rt_data_d  = rt_data_q;
    imm_d      = imm_q;
    alusrc_d   = alusrc_q;
    rd_addr_d  = rd_addr_q;
    regwrite_d = regwrite_q;
    if (flush) begin
      valid_d    = 1'b0;
      alu_op_d   = '0;
      rs_addr_d  = '0;
      rt_addr_d  = '0;
      rs_data_d  = '0;
      rt_data_d  = '0;
      imm_d      = '0;
      alusrc_d   = 1'b0;
      rd_addr_d  = '0;
      regwrite_d = 1'b0;
    end else if (stall) begin
`ifdef EX_FWD_EN
      // A value retiring from WB while we wait would otherwise be lost
      if (wb_hit_rs) rs_data_d = wb_data;
      if (wb_hit_rt) rt_data_d = wb_data;
`endif
    end else begin
      valid_d    = id_valid;
      alu_op_d   = id_alu_op;
      rs_addr_d  = id_rs_addr;
      rt_addr_d  = id_rt_addr;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      rd_addr_d  = id_rd_addr;
      regwrite_d = id_valid & id_regwrite;
`ifdef EX_FWD_EN
      // Regfile is written and read in the same cycle; take the WB value directly
      rs_data_d  = wb_hit_id_rs ? wb_data : id_rs_data;
      rt_data_d  = wb_hit_id_rt ? wb_data : id_rt_data;
`else
      rs_data_d  = id_rs_data;
      rt_data_d  = id_rt_data;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q    <= 1'b0;
      alu_op_q   <= '0;
      rs_addr_q  <= '0;
      rt_addr_q  <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      rd_addr_q  <= '0;
      regwrite_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      alu_op_q   <= alu_op_d;
      rs_addr_q  <= rs_addr_d;
      rt_addr_q  <= rt_addr_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      rd_addr_q  <= rd_addr_d;
      regwrite_q <= regwrite_d;
    end
  end

  // Operand forwarding on held state: MEM is younger than WB, so it wins
  always_comb begin
    fwd_rs = rs_data_q;
    fwd_rt = rt_data_q;
`ifdef EX_FWD_EN
    if (mem_hit_rs)     fwd_rs = mem_result;
    else if (wb_hit_rs) fwd_rs = wb_data;
    if (mem_hit_rt)     fwd_rt = mem_result;
    else if (wb_hit_rt) fwd_rt = wb_data;
`endif
  end

`ifndef EX_FWD_EN
  // Hazard unit stalls until write-back, so the bypass inputs are intentionally ignored
  logic unused_fwd;
  assign unused_fwd = &{1'b0, mem_regwrite, mem_rd_addr, mem_result,
                        wb_regwrite, wb_rd_addr, wb_data, rs_addr_q, rt_addr_q};
`endif

  assign ex_valid    = valid_q;
  assign ex_alu_op   = alu_op_q;
  assign ex_rd_addr  = rd_addr_q;
  assign ex_regwrite = regwrite_q;
  assign ex_A        = fwd_rs;
  assign ex_rt_fwd   = fwd_rt;
  assign ex_B        = alusrc_q ? imm_q : fwd_rt;

endmodule
